// File: rtl/spell_sequencer.sv
// spell_sequencer: instruction sequencer for the SPELL stack CPU.
// Owns pc, sp and the 32-entry byte stack, drives the shared memory port,
// presents operands to the external execute stage and commits its results.
module spell_sequencer #(
    parameter int TICK_CYCLES = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic       ooo_valid,
    input  logic [7:0] ooo_opcode,
    output logic       ooo_ack,
    output logic       mem_req,
    output logic [1:0] mem_type,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack,
    output logic [7:0] ex_opcode,
    output logic [7:0] ex_pc,
    output logic [7:0] ex_stack_top,
    output logic [7:0] ex_stack_belowtop,
    output logic [7:0] ex_memory_input,
    output logic [4:0] ex_sp,
    output logic       ex_out_of_order,
    input  logic [7:0] ex_next_pc,
    input  logic [7:0] ex_set_stack_top,
    input  logic [7:0] ex_set_stack_belowtop,
    input  logic [7:0] ex_memory_write_data,
    input  logic [7:0] ex_memory_write_addr,
    input  logic [7:0] ex_delay_amount,
    input  logic [4:0] ex_next_sp,
    input  logic [1:0] ex_stack_write_count,
    input  logic [1:0] ex_memory_write_type,
    input  logic       ex_sleep,
    output logic [7:0] pc,
    output logic [4:0] sp,
    output logic       busy,
    output logic       sleeping
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    localparam logic [7:0] OP_CODE_READ = 8'h3F;  // '?'
    localparam logic [7:0] OP_DATA_READ = 8'h72;  // 'r'

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_LOAD,
        S_EXEC,
        S_STORE,
        S_DELAY,
        S_SLEEP
    } state_t;

    state_t        state;
    logic [7:0]    opcode;
    logic [7:0]    mem_in;
    logic          out_of_order;
    logic [7:0]    stack [32];
    logic [7:0]    delay_left;
    logic [TW-1:0] tick_cnt;

    logic [4:0]    sp_below;
    logic [4:0]    next_sp_below;
    logic          exec_plain;
    logic          delay_done;
    logic          dispatch;

    assign sp_below      = sp - 5'd1;
    assign next_sp_below = ex_next_sp - 5'd1;

    assign ex_opcode         = opcode;
    assign ex_pc             = pc;
    assign ex_sp             = sp;
    assign ex_stack_top      = stack[sp];
    assign ex_stack_belowtop = stack[sp_below];
    assign ex_memory_input   = mem_in;
    assign ex_out_of_order   = out_of_order;

    assign busy     = (state != S_IDLE);
    assign sleeping = (state == S_SLEEP);

    assign exec_plain = (ex_memory_write_type == 2'b00) && (ex_delay_amount == 8'd0) && !ex_sleep;
    assign delay_done = (tick_cnt == TICK_LAST) && (delay_left == 8'd1);

    // IDLE and the end of every instruction share one dispatch point (the NEXT step)
    always_comb begin
        dispatch = 1'b0;
        case (state)
            S_IDLE:  dispatch = 1'b1;
            S_EXEC:  dispatch = exec_plain;
            S_STORE: dispatch = mem_ack;
            S_DELAY: dispatch = delay_done;
            default: dispatch = 1'b0;
        endcase
    end

    // Sequencer FSM with registered memory-port and handshake outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            pc           <= '0;
            sp           <= '0;
            opcode       <= '0;
            mem_in       <= '0;
            out_of_order <= 1'b0;
            ooo_ack      <= 1'b0;
            mem_req      <= 1'b0;
            mem_type     <= 2'b00;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            delay_left   <= '0;
            tick_cnt     <= '0;
        end else begin
            ooo_ack <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (mem_ack) begin
                        opcode       <= mem_rdata;
                        out_of_order <= 1'b0;
                        mem_req      <= 1'b0;
                        mem_type     <= 2'b00;
                        state        <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (opcode == OP_CODE_READ || opcode == OP_DATA_READ) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_type <= (opcode == OP_CODE_READ) ? 2'b10 : 2'b01;
                        mem_addr <= stack[sp];
                        state    <= S_LOAD;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_LOAD: begin
                    if (mem_ack) begin
                        mem_in   <= mem_rdata;
                        mem_req  <= 1'b0;
                        mem_type <= 2'b00;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    pc <= ex_next_pc;
                    sp <= ex_next_sp;
                    if (ex_memory_write_type != 2'b00) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_type  <= ex_memory_write_type;
                        mem_addr  <= ex_memory_write_addr;
                        mem_wdata <= ex_memory_write_data;
                        state     <= S_STORE;
                    end else if (ex_delay_amount != 8'd0) begin
                        delay_left <= ex_delay_amount;
                        tick_cnt   <= '0;
                        state      <= S_DELAY;
                    end else if (ex_sleep) begin
                        state <= S_SLEEP;
                    end
                end
                S_STORE: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        mem_type <= 2'b00;
                    end
                end
                S_DELAY: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt   <= '0;
                        delay_left <= delay_left - 8'd1;
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                S_SLEEP: begin
                    if (!run) state <= S_IDLE;
                end
                default: ;
            endcase

            // Dispatch overrides the per-state assignments above; leaving EXEC,
            // pc is updated on this same edge, so the fetch uses ex_next_pc.
            if (dispatch) begin
                if (ooo_valid) begin
                    ooo_ack      <= 1'b1;
                    opcode       <= ooo_opcode;
                    out_of_order <= 1'b1;
                    state        <= S_DECODE;
                end else if (run) begin
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_type <= 2'b10;
                    mem_addr <= (state == S_EXEC) ? ex_next_pc : pc;
                    state    <= S_FETCH;
                end else begin
                    state <= S_IDLE;
                end
            end
        end
    end

    // Stack commit from the execute stage; the array itself is never reset
    always_ff @(posedge clock) begin
        if (state == S_EXEC) begin
            if (ex_stack_write_count != 2'd0) stack[ex_next_sp] <= ex_set_stack_top;
            if (ex_stack_write_count >= 2'd2) stack[next_sp_below] <= ex_set_stack_belowtop;
        end
    end

endmodule

// File: tb/tb_spell_sequencer.sv
// Testbench for spell_sequencer: zero-wait memory model, a small execute-stage
// model, and a scoreboard of expected memory transactions per scenario.
module tb_spell_sequencer;

    logic       clock;
    logic       reset;
    logic       run;
    logic       ooo_valid;
    logic [7:0] ooo_opcode;
    logic       ooo_ack;
    logic       mem_req;
    logic [1:0] mem_type;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic [7:0] ex_opcode, ex_pc, ex_stack_top, ex_stack_belowtop, ex_memory_input;
    logic [4:0] ex_sp;
    logic       ex_out_of_order;
    logic [7:0] ex_next_pc, ex_set_stack_top, ex_set_stack_belowtop;
    logic [7:0] ex_memory_write_data, ex_memory_write_addr, ex_delay_amount;
    logic [4:0] ex_next_sp;
    logic [1:0] ex_stack_write_count, ex_memory_write_type;
    logic       ex_sleep;
    logic [7:0] pc;
    logic [4:0] sp;
    logic       busy;
    logic       sleeping;

    spell_sequencer #(.TICK_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .run(run),
        .ooo_valid(ooo_valid), .ooo_opcode(ooo_opcode), .ooo_ack(ooo_ack),
        .mem_req(mem_req), .mem_type(mem_type), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .ex_opcode(ex_opcode), .ex_pc(ex_pc), .ex_stack_top(ex_stack_top),
        .ex_stack_belowtop(ex_stack_belowtop), .ex_memory_input(ex_memory_input),
        .ex_sp(ex_sp), .ex_out_of_order(ex_out_of_order),
        .ex_next_pc(ex_next_pc), .ex_set_stack_top(ex_set_stack_top),
        .ex_set_stack_belowtop(ex_set_stack_belowtop),
        .ex_memory_write_data(ex_memory_write_data), .ex_memory_write_addr(ex_memory_write_addr),
        .ex_delay_amount(ex_delay_amount), .ex_next_sp(ex_next_sp),
        .ex_stack_write_count(ex_stack_write_count), .ex_memory_write_type(ex_memory_write_type),
        .ex_sleep(ex_sleep), .pc(pc), .sp(sp), .busy(busy), .sleeping(sleeping)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory: zero-wait acknowledge unless hold_ack withholds it
    logic [7:0] code_mem [256];
    logic [7:0] data_mem [256];
    logic       hold_ack;
    assign mem_ack   = mem_req && !hold_ack;
    assign mem_rdata = (mem_type == 2'b10) ? code_mem[mem_addr] : data_mem[mem_addr];

    // Execute stage: digits/other bytes push themselves, '+' add, '!' code write,
    // 'r'/'?' replace top with loaded byte, ',' delay by top, 'z' sleep in place
    always_comb begin
        ex_next_pc            = ex_out_of_order ? ex_pc : ex_pc + 8'd1;
        ex_next_sp            = ex_sp;
        ex_set_stack_top      = 8'h00;
        ex_set_stack_belowtop = 8'h00;
        ex_stack_write_count  = 2'd0;
        ex_memory_write_type  = 2'b00;
        ex_memory_write_addr  = 8'h00;
        ex_memory_write_data  = 8'h00;
        ex_delay_amount       = 8'h00;
        ex_sleep              = 1'b0;
        case (ex_opcode)
            8'h2B: begin
                ex_next_sp           = ex_sp - 5'd1;
                ex_set_stack_top     = ex_stack_top + ex_stack_belowtop;
                ex_stack_write_count = 2'd1;
            end
            8'h21: begin
                ex_next_sp           = ex_sp - 5'd2;
                ex_memory_write_type = 2'b10;
                ex_memory_write_addr = ex_stack_top;
                ex_memory_write_data = ex_stack_belowtop;
            end
            8'h72, 8'h3F: begin
                ex_set_stack_top     = ex_memory_input;
                ex_stack_write_count = 2'd1;
            end
            8'h2C: ex_delay_amount = ex_stack_top;
            8'h7A: begin
                ex_next_pc = ex_pc;
                ex_sleep   = 1'b1;
            end
            default: begin
                ex_next_sp           = ex_sp + 5'd1;
                ex_set_stack_top     = ex_opcode;
                ex_stack_write_count = 2'd1;
            end
        endcase
    end

    typedef struct packed {
        logic [1:0] typ;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } txn_t;

    txn_t obs_q[$];
    txn_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ack_cnt  = 0;

    // One cycle: sample at the falling edge and log completed transactions
    task automatic step();
        @(negedge clock);
        if (mem_req && mem_ack)
            obs_q.push_back('{mem_type, mem_we, mem_addr, mem_we ? mem_wdata : 8'h00});
        if (ooo_ack) ack_cnt++;
    endtask

    task automatic do_reset();
        run = 1'b0; ooo_valid = 1'b0; ooo_opcode = 8'h00; hold_ack = 1'b0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        obs_q.delete(); exp_q.delete(); ack_cnt = 0;
    endtask

    task automatic push_fetch(input logic [7:0] a);
        exp_q.push_back('{2'b10, 1'b0, a, 8'h00});
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (pc !== 8'd0) begin n_fail++; $display("FAIL reset_pc: got %0h expected 0", pc); end
        n_checks++; if (sp !== 5'd0) begin n_fail++; $display("FAIL reset_sp: got %0h expected 0", sp); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if ({mem_req, mem_we, mem_type} !== 4'b0000) begin n_fail++; $display("FAIL reset_mem: got %b expected 0000", {mem_req, mem_we, mem_type}); end
        n_checks++; if ({ooo_ack, sleeping} !== 2'b00) begin n_fail++; $display("FAIL reset_ack_sleep: got %b expected 00", {ooo_ack, sleeping}); end
    endtask

    task automatic test_push_add();
        do_reset();
        code_mem[0] = 8'h35; code_mem[1] = 8'h33; code_mem[2] = 8'h2B; code_mem[3] = 8'h7A;
        for (int unsigned a = 0; a < 4; a++) push_fetch(8'(a));
        run = 1'b1;
        for (int i = 0; i < 200 && !sleeping; i++) step();
        n_checks++; if (sleeping !== 1'b1) begin n_fail++; $display("FAIL push_add_timeout: sleeping %b expected 1", sleeping); end
        n_checks++; if (pc !== 8'd3) begin n_fail++; $display("FAIL push_add_pc: got %0h expected 3", pc); end
        n_checks++; if (sp !== 5'd1) begin n_fail++; $display("FAIL push_add_sp: got %0h expected 1", sp); end
        n_checks++; if (ex_stack_top !== 8'h68) begin n_fail++; $display("FAIL push_add_top: got %0h expected 68", ex_stack_top); end
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL push_add_txn_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            txn_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL push_add_txn: got %h expected %h", o, e); end
        end
        run = 1'b0;
        step(); step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL push_add_idle: busy %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_fetch();
        // pc is 3 from the previous program; stall the fetch, then reset mid-cycle
        hold_ack = 1'b1;
        run = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if ({mem_req, mem_we, mem_type, mem_addr} !== {1'b1, 1'b0, 2'b10, 8'd3}) begin
                n_fail++; $display("FAIL stalled_fetch: got %h expected %h", {mem_req, mem_we, mem_type, mem_addr}, {1'b1, 1'b0, 2'b10, 8'd3});
            end
        end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_drops_req: got %b expected 0", mem_req); end
        n_checks++; if ({pc, sp, busy} !== 14'd0) begin n_fail++; $display("FAIL reset_mid_state: got %h expected 0", {pc, sp, busy}); end
        run = 1'b0; hold_ack = 1'b0;
        step();
        reset = 1'b0;
        step();
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_code_write();
        do_reset();
        code_mem[0] = 8'h41; code_mem[1] = 8'h10; code_mem[2] = 8'h21; code_mem[3] = 8'h7A;
        push_fetch(8'd0); push_fetch(8'd1); push_fetch(8'd2);
        exp_q.push_back('{2'b10, 1'b1, 8'h10, 8'h41});
        push_fetch(8'd3);
        run = 1'b1;
        for (int i = 0; i < 200 && !sleeping; i++) step();
        n_checks++; if (sleeping !== 1'b1) begin n_fail++; $display("FAIL code_write_timeout: sleeping %b expected 1", sleeping); end
        n_checks++; if (sp !== 5'd0) begin n_fail++; $display("FAIL code_write_sp: got %0h expected 0", sp); end
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL code_write_txn_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            txn_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL code_write_txn: got %h expected %h", o, e); end
        end
        run = 1'b0;
        step(); step();
    endtask

    task automatic test_data_read();
        do_reset();
        code_mem[0] = 8'h07; code_mem[1] = 8'h72; code_mem[2] = 8'h7A;
        data_mem[7] = 8'h99;
        push_fetch(8'd0); push_fetch(8'd1);
        exp_q.push_back('{2'b01, 1'b0, 8'h07, 8'h00});
        push_fetch(8'd2);
        run = 1'b1;
        for (int i = 0; i < 200 && !sleeping; i++) step();
        n_checks++; if (sleeping !== 1'b1) begin n_fail++; $display("FAIL data_read_timeout: sleeping %b expected 1", sleeping); end
        n_checks++; if (sp !== 5'd1) begin n_fail++; $display("FAIL data_read_sp: got %0h expected 1", sp); end
        n_checks++; if (ex_stack_top !== 8'h99) begin n_fail++; $display("FAIL data_read_top: got %0h expected 99", ex_stack_top); end
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL data_read_txn_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            txn_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL data_read_txn: got %h expected %h", o, e); end
        end
        run = 1'b0;
        step(); step();
    endtask

    task automatic test_delay();
        int  gap;
        bit  found;
        bit  busy_ok;
        do_reset();
        code_mem[0] = 8'h03; code_mem[1] = 8'h2C; code_mem[2] = 8'h7A;
        push_fetch(8'd0); push_fetch(8'd1); push_fetch(8'd2);
        run = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            step();
            found = mem_req && mem_ack && (mem_addr == 8'd1) && (mem_type == 2'b10);
        end
        // DECODE + EXEC + 3 units x 4 ticks without a memory request
        gap = 0; busy_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (mem_req) break;
            if (!busy) busy_ok = 1'b0;
            gap++;
        end
        n_checks++; if (gap != 14) begin n_fail++; $display("FAIL delay_gap: got %0d expected 14", gap); end
        n_checks++; if (busy_ok !== 1'b1) begin n_fail++; $display("FAIL delay_busy: got %b expected 1", busy_ok); end
        n_checks++; if (mem_addr !== 8'd2) begin n_fail++; $display("FAIL delay_next_fetch: got %0h expected 2", mem_addr); end
        for (int i = 0; i < 200 && !sleeping; i++) step();
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL delay_txn_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            txn_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL delay_txn: got %h expected %h", o, e); end
        end
        run = 1'b0;
        step(); step();
    endtask

    task automatic test_out_of_order();
        int sleep_cycles;
        do_reset();
        ooo_opcode = 8'h7A;
        ooo_valid  = 1'b1;
        for (int i = 0; i < 20 && !ooo_ack; i++) step();
        n_checks++; if (ooo_ack !== 1'b1) begin n_fail++; $display("FAIL ooo_ack_timeout: got %b expected 1", ooo_ack); end
        n_checks++; if ({ex_out_of_order, ex_opcode} !== {1'b1, 8'h7A}) begin n_fail++; $display("FAIL ooo_operands: got %h expected 17a", {ex_out_of_order, ex_opcode}); end
        ooo_valid = 1'b0;
        sleep_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (sleeping) sleep_cycles++;
        end
        n_checks++; if (sleep_cycles != 1) begin n_fail++; $display("FAIL ooo_sleep_cycles: got %0d expected 1", sleep_cycles); end
        n_checks++; if (ack_cnt != 1) begin n_fail++; $display("FAIL ooo_ack_count: got %0d expected 1", ack_cnt); end
        n_checks++; if ({busy, pc} !== 9'd0) begin n_fail++; $display("FAIL ooo_end_state: got %h expected 0", {busy, pc}); end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL ooo_no_fetch: got %0d expected 0", obs_q.size()); end
    endtask

    task automatic test_back_to_back();
        int waited;
        do_reset();
        code_mem[0] = 8'h41; code_mem[1] = 8'h42; code_mem[2] = 8'h7A;
        push_fetch(8'd0); push_fetch(8'd1); push_fetch(8'd2);
        run = 1'b1;
        for (int i = 0; i < 20 && obs_q.size() == 0; i++) step();
        // Offered mid-instruction: must wait for DECODE and EXEC of 'A'
        ooo_opcode = 8'h31;
        ooo_valid  = 1'b1;
        waited = 0;
        for (int i = 0; i < 20 && !ooo_ack; i++) begin
            step();
            waited++;
        end
        ooo_valid = 1'b0;
        n_checks++; if (waited != 3) begin n_fail++; $display("FAIL b2b_ack_latency: got %0d expected 3", waited); end
        for (int i = 0; i < 200 && !sleeping; i++) step();
        n_checks++; if (ack_cnt != 1) begin n_fail++; $display("FAIL b2b_ack_count: got %0d expected 1", ack_cnt); end
        n_checks++; if ({pc, sp} !== {8'd2, 5'd3}) begin n_fail++; $display("FAIL b2b_pc_sp: got %h expected %h", {pc, sp}, {8'd2, 5'd3}); end
        n_checks++; if ({ex_stack_top, ex_stack_belowtop} !== 16'h4231) begin n_fail++; $display("FAIL b2b_stack: got %h expected 4231", {ex_stack_top, ex_stack_belowtop}); end
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_txn_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            txn_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL b2b_txn: got %h expected %h", o, e); end
        end
        run = 1'b0;
        step(); step();
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; ooo_valid = 1'b0; ooo_opcode = 8'h00; hold_ack = 1'b0;
        for (int i = 0; i < 256; i++) begin
            code_mem[i] = 8'h7A;
            data_mem[i] = 8'h00;
        end
        test_reset();
        test_push_add();
        test_reset_mid_fetch();
        test_code_write();
        test_data_read();
        test_delay();
        test_out_of_order();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
